// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared states, bus constants and helpers for the I2C target
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ADDR_ACK  = 3'd2,
        WRITE     = 3'd3,
        WRITE_ACK = 3'd4,
        READ      = 3'd5,
        READ_ACK  = 3'd6,
        WAIT_STOP = 3'd7
    } i2c_state_e;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;
    localparam logic I2C_RD   = 1'b1;

    // An empty read source returns all-ones, which looks like a released bus.
    function automatic logic [7:0] tx_pick(input logic valid, input logic [7:0] data);
        return valid ? data : 8'hFF;
    endfunction

endpackage

// File: rtl/i2c_target_rx_tx_if.sv
// rtl/i2c_target_rx_tx_if.sv - AXI-Stream write/read byte channels of the I2C target
interface i2c_target_rx_tx_if;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid;
    logic       s_axis_tready;

    modport master (
        output m_axis_tdata, m_axis_tvalid, s_axis_tready,
        input  m_axis_tready, s_axis_tdata, s_axis_tvalid
    );

    modport slave (
        input  m_axis_tdata, m_axis_tvalid, s_axis_tready,
        output m_axis_tready, s_axis_tdata, s_axis_tvalid
    );
endinterface

// File: rtl/i2c_line_filter.sv
// rtl/i2c_line_filter.sv - 2-flop synchronizer, glitch filter and edge strobes for one bus line
module i2c_line_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk_i,
    input  logic arstn_i,
    input  logic line_i,
    output logic line_o,
    output logic rise_o,
    output logic fall_o
);

    if (FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_len_check
        $error("FILTER_LEN must be in 1..15");
    end

    logic       sync1_q, sync2_q, filt_q, rise_q, fall_q;
    logic [3:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            cnt_q   <= 4'd0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            // Count consecutive samples that disagree with the output; any agreeing sample restarts the run.
            if (sync2_q == filt_q) begin
                cnt_q <= 4'd0;
            end else if (cnt_q == 4'(FILTER_LEN - 1)) begin
                filt_q <= sync2_q;
                cnt_q  <= 4'd0;
                rise_q <= sync2_q;
                fall_q <= ~sync2_q;
            end else begin
                cnt_q <= cnt_q + 4'd1;
            end
        end
    end

    assign line_o = filt_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/i2c_target_rx_tx.sv
// rtl/i2c_target_rx_tx.sv - oversampling I2C target bridging bus writes/reads to AXI-Stream
module i2c_target_rx_tx
    import i2c_pkg::*;
#(
    parameter int         CLK_IN      = 100_000_000,
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         FILTER_LEN  = 3
) (
    input  logic clk_i,
    input  logic arstn_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_oe_o,
    output logic busy_o,
    output logic stop_o,
    i2c_target_rx_tx_if.master axis
);

    if (CLK_IN < 2_000_000) begin : g_clk_check
        $error("CLK_IN too low to oversample a 100 kHz bus");
    end

    localparam logic [2:0] ST_IDLE      = 3'(IDLE);
    localparam logic [2:0] ST_ADDR      = 3'(ADDR);
    localparam logic [2:0] ST_ADDR_ACK  = 3'(ADDR_ACK);
    localparam logic [2:0] ST_WRITE     = 3'(WRITE);
    localparam logic [2:0] ST_WRITE_ACK = 3'(WRITE_ACK);
    localparam logic [2:0] ST_READ      = 3'(READ);
    localparam logic [2:0] ST_READ_ACK  = 3'(READ_ACK);
    localparam logic [2:0] ST_WAIT_STOP = 3'(WAIT_STOP);

    logic scl_f, scl_rise, scl_fall, sda_f, sda_rise, sda_fall;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
        .clk_i(clk_i), .arstn_i(arstn_i), .line_i(scl_i),
        .line_o(scl_f), .rise_o(scl_rise), .fall_o(scl_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
        .clk_i(clk_i), .arstn_i(arstn_i), .line_i(sda_i),
        .line_o(sda_f), .rise_o(sda_rise), .fall_o(sda_fall)
    );

    logic [2:0] state_q, state_d, bitcnt_q, bitcnt_d;
    logic [6:0] shift_q, shift_d;
    logic [7:0] tx_q, tx_d, m_tdata_q, m_tdata_d;
    logic       rw_q, rw_d, phase_q, phase_d, ack_q, ack_d;
    logic       sda_oe_q, sda_oe_d, busy_q, busy_d, stop_q, stop_d;
    logic       m_tvalid_q, m_tvalid_d, s_tready_q, s_tready_d;
    logic [7:0] rx_byte, tx_byte;
    logic       start_cond, stop_cond, wr_free;

    assign start_cond = sda_fall && scl_f;
    assign stop_cond  = sda_rise && scl_f;

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        rw_d       = rw_q;
        phase_d    = phase_q;
        ack_d      = ack_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        stop_d     = 1'b0;
        m_tdata_d  = m_tdata_q;
        m_tvalid_d = m_tvalid_q;
        s_tready_d = 1'b0;
        rx_byte    = {shift_q, sda_f};
        tx_byte    = tx_pick(axis.s_axis_tvalid, axis.s_axis_tdata);
        // A same-cycle downstream accept frees the holding register for the byte completing now.
        wr_free    = !m_tvalid_q || axis.m_axis_tready;

        if (m_tvalid_q && axis.m_axis_tready) m_tvalid_d = 1'b0;

        if (stop_cond) begin
            state_d  = ST_IDLE;
            bitcnt_d = 3'd0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            stop_d   = 1'b1;
        end else if (start_cond) begin
            state_d  = ST_ADDR;
            bitcnt_d = 3'd0;
            sda_oe_d = 1'b0;
            phase_d  = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: if (scl_rise) begin
                    shift_d  = rx_byte[6:0];
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        if (shift_q == TARGET_ADDR) begin
                            state_d = ST_ADDR_ACK;
                            rw_d    = sda_f;
                            busy_d  = 1'b1;
                            phase_d = 1'b0;
                        end else begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                        end
                    end
                end
                ST_ADDR_ACK: if (scl_fall) begin
                    if (!phase_q) begin
                        sda_oe_d = 1'b1;
                        phase_d  = 1'b1;
                    end else begin
                        phase_d  = 1'b0;
                        bitcnt_d = 3'd0;
                        if (rw_q == I2C_RD) begin
                            state_d    = ST_READ;
                            tx_d       = {tx_byte[6:0], 1'b0};
                            sda_oe_d   = ~tx_byte[7];
                            s_tready_d = axis.s_axis_tvalid;
                        end else begin
                            state_d  = ST_WRITE;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                ST_WRITE: if (scl_rise) begin
                    shift_d  = rx_byte[6:0];
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = ST_WRITE_ACK;
                        phase_d = 1'b0;
                        ack_d   = wr_free ? I2C_ACK : I2C_NACK;
                        if (wr_free) begin
                            m_tdata_d  = rx_byte;
                            m_tvalid_d = 1'b1;
                        end
                    end
                end
                ST_WRITE_ACK: if (scl_fall) begin
                    if (!phase_q) begin
                        sda_oe_d = (ack_q == I2C_ACK);
                        phase_d  = 1'b1;
                    end else begin
                        sda_oe_d = 1'b0;
                        phase_d  = 1'b0;
                        state_d  = ST_WRITE;
                    end
                end
                ST_READ: if (scl_fall) begin
                    if (bitcnt_q == 3'd7) begin
                        sda_oe_d = 1'b0;
                        bitcnt_d = 3'd0;
                        phase_d  = 1'b0;
                        state_d  = ST_READ_ACK;
                    end else begin
                        sda_oe_d = ~tx_q[7];
                        tx_d     = {tx_q[6:0], 1'b0};
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end
                ST_READ_ACK: begin
                    if (scl_rise) begin
                        if (sda_f == I2C_ACK) phase_d = 1'b1;
                        else                  state_d = ST_WAIT_STOP;
                    end else if (scl_fall && phase_q) begin
                        phase_d    = 1'b0;
                        state_d    = ST_READ;
                        tx_d       = {tx_byte[6:0], 1'b0};
                        sda_oe_d   = ~tx_byte[7];
                        s_tready_d = axis.s_axis_tvalid;
                    end
                end
                ST_WAIT_STOP: sda_oe_d = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            state_q    <= ST_IDLE;
            bitcnt_q   <= 3'd0;
            shift_q    <= 7'd0;
            tx_q       <= 8'd0;
            rw_q       <= 1'b0;
            phase_q    <= 1'b0;
            ack_q      <= I2C_NACK;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            stop_q     <= 1'b0;
            m_tdata_q  <= 8'd0;
            m_tvalid_q <= 1'b0;
            s_tready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            rw_q       <= rw_d;
            phase_q    <= phase_d;
            ack_q      <= ack_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            stop_q     <= stop_d;
            m_tdata_q  <= m_tdata_d;
            m_tvalid_q <= m_tvalid_d;
            s_tready_q <= s_tready_d;
        end
    end

    assign sda_oe_o           = sda_oe_q;
    assign busy_o             = busy_q;
    assign stop_o             = stop_q;
    assign axis.m_axis_tdata  = m_tdata_q;
    assign axis.m_axis_tvalid = m_tvalid_q;
    assign axis.s_axis_tready = s_tready_q;

endmodule
